calc_display_engine: RTL
========================

# calc_display_engine

Parametrised calculator-to-display engine: registers two WIDTH-bit operands and an opcode on a `start` strobe, computes the result, and converts it to BCD with a sequential double-dabble converter. The result then appears on a DIGITS-wide multiplexed seven-segment display with a start/busy/done handshake, sign display, leading-zero blanking and a divide-by-zero error indication. It is the next-generation replacement for the fixed 4-bit calculator/BCD/display chain at the top of the board design.

## Interface
- `WIDTH`, default 4: operand width; result width RW = 2*WIDTH.
- `DIGITS`, default 4: display digits. Must satisfy DIGITS ≥ (decimal digits of 2^RW−1) + 1; elaboration fails otherwise.
- `REFRESH_DIV`, default 100000: clock cycles each digit is driven (≥ 2).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `a` in WIDTH: operand A, unsigned.
- `b` in WIDTH: operand B, unsigned.
- `opp` in 3: opcode. 000 add, 001 sub, 010 mul, 011 div (quotient), 100 mod, 101 and, 110 or, 111 xor.
- `start` in 1: request; sampled only in IDLE.
- `busy` out 1: high from the accepting edge until `done`.
- `done` out 1: one-cycle pulse when the new value is loaded to the display.
- `err` out 1: divide/mod by zero on the last completed operation; holds until the next accepted `start`.
- `sseg_a_o` out DIGITS: digit anodes, active-low, exactly one low at all times.
- `sseg_c_o` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- The FSM has three states: IDLE, CONV and LOAD.
- IDLE with `start`=1:
  - capture the magnitude of the result into the converter;
  - capture `neg` and `err_n`;
  - set `busy`; go to CONV.
- Arithmetic, zero-extended to RW bits:
  - add, mul, and, or and xor are unsigned;
  - sub gives |a−b| with `neg`=(a<b);
  - div/mod with b=0 forces magnitude 0 and `err_n`=1.
- CONV runs exactly RW double-dabble cycles: add 3 to each BCD nibble ≥ 5, then shift left 1. The state then goes to LOAD.
- LOAD does the following in one step:
  - copies the BCD digits, `neg` and `err_n` into the display register;
  - pulses `done`, clears `busy`, and returns to IDLE.
- `start` outside IDLE is ignored, not queued. Operand and opcode changes after acceptance have no effect.
- The display register only changes in LOAD; it holds the last result indefinitely.
- Digit rendering, for digit index i:
  - leading zeros are blanked; digit 0 always shows, so the value 0 renders as "   0";
  - if `neg`, digit DIGITS−1 shows minus (segment g only);
  - if `err`, digit 0 shows "E" and all other digits are blank.
- Scan: a counter counts 0..REFRESH_DIV−1; at wrap the digit index advances i → (i+1) mod DIGITS. The anode and cathode for index i are driven together from registers, so there is no ghosting.

## Timing
- Reset values:
  - FSM in IDLE; `busy`=0, `done`=0, `err`=0;
  - display register all-blank with `neg`=0;
  - scan index 0, `sseg_a_o` = all ones except bit 0 = 0;
  - `sseg_c_o` = 7'h7F.
- Latency: `start` sampled at edge k → `busy`=1 after edge k. `done`=1 for the single cycle following edge k+RW+1, with `busy`=0 in that same cycle. The default is 9 cycles from edge k.
- The new digits appear on the display from the cycle after `done`, at the current scan position. Scanning is never reset by a conversion.
- Back-to-back: `start` held high continuously is accepted on the edge after `done` clears (the IDLE cycle), giving one operation per RW+2 cycles.
- Reset mid-conversion aborts immediately: no `done`, and the display returns to blank.

## Structure
- Package `calc_pkg` holds:
  - opcode localparams;
  - FSM state encoding;
  - seven-segment constants (digits 0–9, BLANK=7'h7F, MINUS, E_CHAR);
  - a function computing the required digit count from RW.
- One sub-module, `bcd_seq_conv`, is parametrised on input width and digit count. It has a load/shift interface and a done flag.
- Opcode decode, FSM and display scan live in the top module.

## Test plan
Use REFRESH_DIV=4 and default WIDTH/DIGITS.
- Reset: assert `rst_n`=0 mid-simulation → `busy`=0, `done`=0, `err`=0, `sseg_a_o`=4'b1110, `sseg_c_o`=7'h7F, all asynchronously.
- Add: a=9, b=7, opp=000 with `start` pulse → `done` exactly 9 cycles after the sampling edge. Scanning shows blank, blank, '1', '6'; `err`=0.
- Subtract: a=3, b=9, opp=001 → display "-  6", with the leftmost digit at segment g only.
- Multiply maximum and divide: 15×15 gives "225" with digit 3 blank; 14 div 4 gives "3"; 14 mod 4 gives "2".
- Divide by zero: a=5, b=0, opp=011 → `err`=1 at `done`, display "   E". The next valid `start` clears `err` at acceptance.
- Handshake abuse: a `start` pulse during CONV is ignored (exactly one `done`). `rst_n` low at cycle 4 of CONV → no `done`, display blank. Operands changed during CONV do not alter the result.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding, seven-segment patterns and sizing helper
// for the calculator-to-display engine.
package calc_pkg;

    // Opcode encoding on the opp input
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0  = 7'h40;
    localparam logic [6:0] SEG_1  = 7'h79;
    localparam logic [6:0] SEG_2  = 7'h24;
    localparam logic [6:0] SEG_3  = 7'h30;
    localparam logic [6:0] SEG_4  = 7'h19;
    localparam logic [6:0] SEG_5  = 7'h12;
    localparam logic [6:0] SEG_6  = 7'h02;
    localparam logic [6:0] SEG_7  = 7'h78;
    localparam logic [6:0] SEG_8  = 7'h00;
    localparam logic [6:0] SEG_9  = 7'h10;
    localparam logic [6:0] BLANK  = 7'h7F;
    localparam logic [6:0] MINUS  = 7'h3F;
    localparam logic [6:0] E_CHAR = 7'h06;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Number of decimal digits needed to show 2^rw - 1
    function automatic int calc_digits(input int rw);
        logic [63:0] v;
        int          n;
        v = (64'd1 << rw) - 64'd1;
        n = 1;
        v = v / 64'd10;
        while (v != 64'd0) begin
            n = n + 1;
            v = v / 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle,
// IN_W cycles per conversion after a load.
module bcd_seq_conv
    import calc_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [IN_W-1:0]       bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  done
);

    localparam int CNT_W = $clog2(IN_W + 1);

    logic [CNT_W-1:0]     cnt;
    logic [IN_W-1:0]      bin_sr;
    logic [4*DIGITS-1:0]  bcd_sr;
    logic [4*DIGITS-1:0]  adj;

    // Add-3 correction of every nibble that would overflow on the next shift
    always_comb begin
        adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Remaining-shift counter; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(IN_W);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    // Shift datapath, no reset needed: always reloaded before use
    always_ff @(posedge clk) begin
        if (load) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
        end else if (cnt != '0) begin
            bcd_sr <= {adj[4*DIGITS-2:0], bin_sr[IN_W-1]};
            bin_sr <= {bin_sr[IN_W-2:0], 1'b0};
        end
    end

    // done marks the cycle whose closing edge performs the final shift
    assign done    = (cnt == CNT_W'(1));
    assign bcd_out = bcd_sr;

endmodule

// File: rtl/calc_display_engine.sv
// Calculator front end: opcode decode, control FSM, display register and
// multiplexed seven-segment scan around the sequential BCD converter.
module calc_display_engine
    import calc_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        opp,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DIGITS-1:0] sseg_a_o,
    output logic [6:0]        sseg_c_o
);

    localparam int RW    = 2 * WIDTH;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    generate
        if (DIGITS < calc_digits(RW) + 1) begin : g_digits_check
            $error("calc_display_engine: DIGITS too small for result width");
        end
    endgenerate

    state_t               state, state_next;
    logic                 conv_load, disp_load, conv_done;
    logic [RW-1:0]        mag;
    logic                 neg_c, err_c;
    logic                 neg_r, err_r;
    logic [4*DIGITS-1:0]  conv_bcd;
    logic [4*DIGITS-1:0]  disp_bcd;
    logic                 disp_blank, disp_neg, disp_err;
    logic [CNT_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]     scan_idx;
    logic [4*DIGITS-1:0]  shifted;
    logic [6:0]           seg_sel;
    logic [DIGITS-1:0]    an_sel;

    // Result magnitude, sign and error flag from the live operands
    always_comb begin
        mag   = '0;
        neg_c = 1'b0;
        err_c = 1'b0;
        case (opp)
            OP_ADD: mag = RW'(a) + RW'(b);
            OP_SUB: begin
                if (a < b) begin
                    mag   = RW'(b - a);
                    neg_c = 1'b1;
                end else begin
                    mag = RW'(a - b);
                end
            end
            OP_MUL: mag = RW'(a) * RW'(b);
            OP_DIV: begin
                if (b == '0) err_c = 1'b1;
                else         mag   = RW'(a / b);
            end
            OP_MOD: begin
                if (b == '0) err_c = 1'b1;
                else         mag   = RW'(a % b);
            end
            OP_AND:  mag = RW'(a & b);
            OP_OR:   mag = RW'(a | b);
            default: mag = RW'(a ^ b);
        endcase
    end

    bcd_seq_conv #(
        .IN_W   (RW),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (conv_load),
        .bin_in  (mag),
        .bcd_out (conv_bcd),
        .done    (conv_done)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and strobes: accept in IDLE, wait out the shifts, then load
    always_comb begin
        state_next = state;
        conv_load  = 1'b0;
        disp_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    conv_load  = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                disp_load  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs and flags captured at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            neg_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            done <= disp_load;
            if (conv_load) begin
                busy  <= 1'b1;
                err   <= 1'b0;
                neg_r <= neg_c;
                err_r <= err_c;
            end else if (disp_load) begin
                busy <= 1'b0;
                err  <= err_r;
            end
        end
    end

    // Display flags: blank until the first completed operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_blank <= 1'b1;
            disp_neg   <= 1'b0;
            disp_err   <= 1'b0;
        end else if (disp_load) begin
            disp_blank <= 1'b0;
            disp_neg   <= neg_r;
            disp_err   <= err_r;
        end
    end

    // Display digits, only meaningful once disp_blank has cleared
    always_ff @(posedge clk) begin
        if (disp_load) disp_bcd <= conv_bcd;
    end

    // Pattern for the digit currently selected by the scan index
    always_comb begin
        shifted = disp_bcd >> {scan_idx, 2'b00};
        seg_sel = BLANK;
        if (disp_blank)
            seg_sel = BLANK;
        else if (disp_err)
            seg_sel = (scan_idx == '0) ? E_CHAR : BLANK;
        else if (disp_neg && scan_idx == IDX_W'(DIGITS - 1))
            seg_sel = MINUS;
        else if (scan_idx == '0 || shifted != '0)
            seg_sel = seg_of(shifted[3:0]);
    end

    // Active-low one-hot anode for the scan index
    always_comb begin
        an_sel           = '1;
        an_sel[scan_idx] = 1'b0;
    end

    // Scan timer and registered anode/cathode pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            sseg_a_o <= {{(DIGITS-1){1'b1}}, 1'b0};
            sseg_c_o <= BLANK;
        end else begin
            if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            sseg_a_o <= an_sel;
            sseg_c_o <= seg_sel;
        end
    end

endmodule
